// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte-stream loader writing 32-bit words into instruction memory
module instr_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_nx;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [23:0] shift;

  logic        xfer;
  logic        idle_like;
  logic [15:0] len_rx;
  logic [31:0] shift_nx;
  logic        last_word;

  assign xfer      = byte_valid & byte_ready;
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign len_rx    = {len_hi, byte_data};
  assign shift_nx  = {shift, byte_data};
  assign last_word = (word_cnt + 16'd1) == len;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_rx == 16'd0)                state_nx = S_CHECK;
          else if ({1'b0, len_rx} > MAX_LEN)  state_nx = S_ERROR;
          else                                state_nx = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_cnt == 2'd3 && last_word) state_nx = S_CHECK;
      S_CHECK: if (xfer) state_nx = (byte_data == csum) ? S_DONE : S_ERROR;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy       = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
  assign byte_ready = busy;
  assign cpu_hold   = busy || (state == S_ERROR);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      len_hi     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      if (start && idle_like) begin
        len_hi    <= '0;
        len       <= '0;
        word_cnt  <= '0;
        byte_cnt  <= '0;
        csum      <= '0;
        imem_addr <= '0;
      end
      // the checksum byte itself is compared, never folded in
      if (xfer && state != S_CHECK) csum <= csum ^ byte_data;
      case (state)
        S_LEN_HI: if (xfer) len_hi <= byte_data;
        S_LEN_LO: if (xfer) len <= len_rx;
        S_DATA: begin
          if (xfer) begin
            shift    <= shift_nx[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= shift_nx;
              imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              word_cnt   <= word_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        reset_n, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_hold, busy, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  instr_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, rd_drops = 0;
  logic        prev_we = 1'b0;
  logic [7:0]  cap_addr[$];
  logic [31:0] cap_data[$];
  logic [7:0]  fq[$];
  logic [31:0] wq[$];

  typedef struct {
    int n; bit corrupt; int gap; bit reuse;
    bit exp_done; bit exp_err; int exp_writes;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
      n_cmp++;
      if (prev_we) begin
        n_bad++;
        $display("FAIL we_width: got 2+ cycles want 1");
      end
    end
    if (busy && !byte_ready) rd_drops++;
    prev_we = imem_we;
  end

  // Frame built from the format rules: length, big-endian words, XOR of all prior bytes.
  task automatic build(input int n, input bit corrupt, input bit reuse);
    logic [7:0] cs;
    logic [15:0] n16;
    n16 = 16'(n);
    if (!reuse) begin
      wq.delete();
      if (n <= 256) for (int i = 0; i < n; i++) wq.push_back($urandom);
    end
    fq.delete();
    fq.push_back(n16[15:8]);
    fq.push_back(n16[7:0]);
    foreach (wq[i]) for (int b = 3; b >= 0; b--) fq.push_back(wq[i][b*8 +: 8]);
    cs = 8'h00;
    foreach (fq[i]) cs = cs ^ fq[i];
    fq.push_back(cs ^ {7'd0, corrupt});
  endtask

  task automatic xfer(input logic [7:0] b, input int gap_pct);
    bit ok;
    if (gap_pct > 0)
      while ($urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (byte_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("xfer_timeout", 0, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    cap_addr.delete();
    cap_data.delete();
    rd_drops = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int exp_n);
    chk({tag, "_wr_count"}, cap_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < cap_addr.size(); i++) begin
      chk({tag, "_addr"}, cap_addr[i], i);
      chk({tag, "_data"}, cap_data[i], wq[i]);
    end
  endtask

  task automatic run_vec(input string tag, input int n, input bit corrupt, input int gap,
                         input bit reuse, input bit e_done, input bit e_err, input int e_wr);
    int nsend;
    build(n, corrupt, reuse);
    do_start();
    nsend = (n > 256) ? 2 : fq.size();
    for (int i = 0; i < nsend; i++) xfer(fq[i], gap);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_error"}, error, e_err);
    chk({tag, "_hold"}, cpu_hold, e_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_ready_drop"}, rd_drops, 0);
    check_writes(tag, e_wr);
  endtask

  initial begin
    vecs = '{
      '{1,   0, 0,  0, 1, 0, 1},
      '{3,   0, 0,  0, 1, 0, 3},
      '{3,   1, 0,  1, 0, 1, 3},
      '{3,   0, 0,  0, 1, 0, 3},
      '{0,   0, 0,  0, 1, 0, 0},
      '{0,   1, 0,  0, 0, 1, 0},
      '{16,  0, 0,  0, 1, 0, 16},
      '{16,  0, 50, 1, 1, 0, 16},
      '{257, 0, 0,  0, 0, 1, 0},
      '{256, 0, 30, 0, 1, 0, 256},
      '{5,   1, 50, 0, 0, 1, 5}
    };
    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Known single-word frame with checksum 0x25
    wq.delete();
    wq.push_back(32'h3C08_0010);
    fq = '{8'h00, 8'h01, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h25};
    do_start();
    foreach (fq[i]) xfer(fq[i], 0);
    repeat (2) @(posedge clk);
    #1;
    chk("single_done", done, 1);
    chk("single_hold", cpu_hold, 0);
    check_writes("single", 1);

    foreach (vecs[v])
      run_vec($sformatf("vec%0d", v), vecs[v].n, vecs[v].corrupt, vecs[v].gap,
              vecs[v].reuse, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes);

    for (int r = 0; r < 4; r++) begin
      int n; bit c;
      n = $urandom_range(1, 20);
      c = 1'($urandom_range(1));
      run_vec($sformatf("rnd%0d", r), n, c, $urandom_range(60), 0, !c, c, n);
    end

    // Reset in the middle of a two-word load, after six data bytes
    build(2, 0, 0);
    do_start();
    for (int i = 0; i < 8; i++) xfer(fq[i], 0);
    chk("midreset_first_word", cap_addr.size(), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_outputs", {byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after_reset", 2, 0, 0, 0, 1, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
